// File: rtl/nvram_upload_ctrl_if.sv
// Purpose: hps_io ioctl upload signals plus the NVRAM secondary read port, bundled as one bus.
// Latency: none; this is wiring only.
// Backpressure: the controller holds ioctl_wait high until ioctl_din is valid.
// Ports: ioctl_upload/index/addr/rd come from hps_io, ioctl_din/wait go back to it;
//        ram_addr/ram_rd go to williams_ram, ram_q comes back from it.
// master = hps_io + RAM side, slave = nvram_upload_ctrl.
interface nvram_upload_ctrl_if #(
  parameter int AW = 10
);
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic [24:0]   ioctl_addr;
  logic          ioctl_rd;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_q;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, ram_q,
    input  ioctl_din, ioctl_wait, ram_addr, ram_rd
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd, ram_q,
    output ioctl_din, ioctl_wait, ram_addr, ram_rd
  );
endinterface

// File: rtl/nvram_upload_ctrl.sv
// Purpose: serves hps_io NVRAM uploads from williams_ram and tracks whether NVRAM changed since the last full save.
// Latency: ioctl_rd at T -> ram_rd at T+1 -> ioctl_din valid at T+2+RD_LAT; out-of-range reads answer 8'hFF at T+2.
// Backpressure: ioctl_wait is held high from T+1 until ioctl_din is valid; strobes arriving while busy are dropped.
// Ports: clk_sys, reset_n (synchronous, active-low); bus (slave): ioctl_* to hps_io, ram_* to the RAM read port;
//        cpu_nv_wr: CPU NVRAM write strobe; nvram_dirty: unsaved changes exist; busy: FSM not idle.
// RD_LAT must lie in 1..4.
module nvram_upload_ctrl #(
  parameter int AW     = 10,
  parameter int RD_LAT = 1,
  parameter int INDEX  = 4
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  nvram_upload_ctrl_if.slave  bus,
  input  logic                cpu_nv_wr,
  output logic                nvram_dirty,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OOR   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic          ram_rd_q, ram_rd_d;
  logic          dirty_q, dirty_d;
  logic          wr_during_q, wr_during_d;
  logic          last_seen_q, last_seen_d;
  logic          active_q;

  logic          active;
  logic          active_rise;
  logic          active_fall;
  logic          in_range;

  assign active      = bus.ioctl_upload & (bus.ioctl_index == 8'(INDEX));
  assign active_rise = active & ~active_q;
  assign active_fall = ~active & active_q;
  // Any set bit above the image size means the address lies past the end of NVRAM.
  assign in_range    = (bus.ioctl_addr[24:AW] == '0);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      din_q       <= '0;
      wait_q      <= 1'b0;
      ram_addr_q  <= '0;
      ram_rd_q    <= 1'b0;
      dirty_q     <= 1'b0;
      wr_during_q <= 1'b0;
      last_seen_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      ram_addr_q  <= ram_addr_d;
      ram_rd_q    <= ram_rd_d;
      dirty_q     <= dirty_d;
      wr_during_q <= wr_during_d;
      last_seen_q <= last_seen_d;
      active_q    <= active;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    din_d       = din_q;
    wait_d      = wait_q;
    ram_addr_d  = ram_addr_q;
    ram_rd_d    = 1'b0;
    dirty_d     = dirty_q;
    wr_during_d = wr_during_q;
    last_seen_d = last_seen_q;

    case (state_q)
      IDLE: begin
        if (bus.ioctl_rd && active) begin
          wait_d = 1'b1;
          if (in_range) begin
            ram_addr_d = bus.ioctl_addr[AW-1:0];
            ram_rd_d   = 1'b1;
            cnt_d      = 3'(RD_LAT);
            state_d    = FETCH;
          end else begin
            state_d = OOR;
          end
        end
      end

      FETCH: begin
        // Abort leaves ioctl_din untouched so hps_io never sees a torn byte.
        if (!active) begin
          wait_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == 3'd0) begin
          din_d   = bus.ram_q;
          wait_d  = 1'b0;
          state_d = IDLE;
          if (&ram_addr_q) begin
            last_seen_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      OOR: begin
        if (!active) begin
          wait_d  = 1'b0;
          state_d = IDLE;
        end else begin
          din_d       = 8'hFF;
          wait_d      = 1'b0;
          last_seen_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        wait_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // A new upload session starts with a clean record. The FSM cannot set
    // last_seen on a rising edge because it needs active in the prior cycle.
    if (active_rise) begin
      wr_during_d = 1'b0;
      last_seen_d = 1'b0;
    end
    if (cpu_nv_wr && active) begin
      wr_during_d = 1'b1;
    end

    // Only a session that reached the end of the image with no CPU writes
    // counts as a complete save; a write in the clearing cycle still wins.
    if (active_fall && last_seen_q && !wr_during_q) begin
      dirty_d = 1'b0;
    end
    if (cpu_nv_wr) begin
      dirty_d = 1'b1;
    end
  end

  assign bus.ioctl_din  = din_q;
  assign bus.ioctl_wait = wait_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_rd     = ram_rd_q;
  assign nvram_dirty    = dirty_q;
  assign busy           = (state_q != IDLE);

endmodule
